// File: rtl/forward_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// forward_hazard_ctrl_pkg
// Shared definitions for the EX-stage operand forwarding control and the EX
// stage operand muxes:
//   - fwd_sel_e     : operand select encoding (regfile / EX/MEM / MEM/WB)
//   - stage_entry_t : per-stage producer record {valid, dest, wr, load}
//   - produces()    : does a stage entry forward a given source register
// -----------------------------------------------------------------------------
package forward_hazard_ctrl_pkg;

   // Destination field width inside a stage entry. Register indices narrower
   // than this are zero-extended on entry, so REG_W may be at most this value.
   localparam int unsigned ENTRY_DEST_W = 8;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,   // operand from register file
      FWD_EXMEM = 2'b01,   // operand from EX/MEM result
      FWD_MEMWB = 2'b10    // operand from MEM/WB result
   } fwd_sel_e;

   typedef struct packed {
      logic                    valid;
      logic [ENTRY_DEST_W-1:0] dest;
      logic                    wr;
      logic                    load;
   } stage_entry_t;

   // True when entry e holds a live producer of a non-zero register src.
   function automatic logic produces(input stage_entry_t e,
                                     input logic [ENTRY_DEST_W-1:0] src);
      return e.valid & e.wr & (src != '0) & (e.dest == src);
   endfunction

endpackage

// File: rtl/forward_hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Combinational forwarding select for one source operand.
// Ports:
//   src_i   : source register index (zero-extended)
//   uses_i  : instruction actually reads src_i
//   ex_i    : producer entry currently in EX  (will be in MEM next cycle)
//   mem_i   : producer entry currently in MEM (will be in WB next cycle)
//   sel_o   : FWD_EXMEM / FWD_MEMWB / FWD_REG, newest producer wins
// -----------------------------------------------------------------------------
module fwd_select
   import forward_hazard_ctrl_pkg::*;
(
   input  logic [ENTRY_DEST_W-1:0] src_i,
   input  logic                    uses_i,
   input  stage_entry_t            ex_i,
   input  stage_entry_t            mem_i,
   output logic [1:0]              sel_o
);

   always_comb begin
      sel_o = FWD_REG;
      if (uses_i && produces(ex_i, src_i)) begin
         sel_o = FWD_EXMEM;
      end else if (uses_i && produces(mem_i, src_i)) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// forward_hazard_ctrl
// Control side of the EX-stage operand forwarding path. Tracks producers in
// EX and MEM, registers the rs/rt operand selects for the instruction entering
// EX, and raises a load-use stall towards IF/ID.
// Ports:
//   clock, reset_n        : rising-edge clock, synchronous active-low reset
//   hold                  : global freeze, all state holds
//   flush                 : kill the instruction in ID
//   id_valid              : ID holds a real instruction
//   id_rs/id_rt           : source registers, id_uses_rs/id_uses_rt qualify them
//   id_dest, id_reg_write : destination register and its write enable
//   id_is_load            : instruction is a load
//   stall                 : combinational freeze of PC/IFID, bubble into EX
//   rsMux/rtMux           : registered EX operand selects (fwd_sel_e encoding)
//   stall_count           : saturating count of stall cycles
// REG_W must not exceed ENTRY_DEST_W.
// -----------------------------------------------------------------------------
module forward_hazard_ctrl
   import forward_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   output logic             stall,
   output logic [1:0]       rsMux,
   output logic [1:0]       rtMux,
   output logic [CNT_W-1:0] stall_count
);

   // Only EX and MEM producers are tracked: a WB producer is covered by the
   // register file writing in the first half-cycle and reading in the second.
   stage_entry_t            ex_q, ex_d;
   stage_entry_t            mem_q, mem_d;
   logic [1:0]              rs_sel_q, rs_sel_d;
   logic [1:0]              rt_sel_q, rt_sel_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [ENTRY_DEST_W-1:0] rs_ext, rt_ext, dest_ext;
   logic [1:0]              rs_sel, rt_sel;
   logic                    ex_load_pending;

   assign rs_ext   = ENTRY_DEST_W'(id_rs);
   assign rt_ext   = ENTRY_DEST_W'(id_rt);
   assign dest_ext = ENTRY_DEST_W'(id_dest);

   fwd_select u_rs_sel (
      .src_i  (rs_ext),
      .uses_i (id_uses_rs),
      .ex_i   (ex_q),
      .mem_i  (mem_q),
      .sel_o  (rs_sel)
   );

   fwd_select u_rt_sel (
      .src_i  (rt_ext),
      .uses_i (id_uses_rt),
      .ex_i   (ex_q),
      .mem_i  (mem_q),
      .sel_o  (rt_sel)
   );

   // A load in EX cannot forward from EX/MEM; a dependent reader waits one
   // cycle and then picks the value up from MEM/WB.
   assign ex_load_pending = ex_q.valid & ex_q.load & ex_q.wr & (ex_q.dest != '0);

   assign stall = id_valid & ~flush & ex_load_pending &
                  ((id_uses_rs & (rs_ext == ex_q.dest)) |
                   (id_uses_rt & (rt_ext == ex_q.dest)));

   always_comb begin
      ex_d     = ex_q;
      mem_d    = mem_q;
      rs_sel_d = rs_sel_q;
      rt_sel_d = rt_sel_q;
      cnt_d    = cnt_q;
      if (!hold) begin
         mem_d = ex_q;
         if (flush || stall || !id_valid) begin
            ex_d     = '0;
            rs_sel_d = FWD_REG;
            rt_sel_d = FWD_REG;
         end else begin
            ex_d.valid = 1'b1;
            ex_d.dest  = dest_ext;
            ex_d.wr    = id_reg_write;
            ex_d.load  = id_is_load;
            rs_sel_d   = rs_sel;
            rt_sel_d   = rt_sel;
         end
         if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ex_q     <= '0;
         mem_q    <= '0;
         rs_sel_q <= FWD_REG;
         rt_sel_q <= FWD_REG;
         cnt_q    <= '0;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         rs_sel_q <= rs_sel_d;
         rt_sel_q <= rt_sel_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rsMux       = rs_sel_q;
   assign rtMux       = rt_sel_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_ctrl
// Table-driven bench for forward_hazard_ctrl. Each record is one ID-stage
// cycle: inputs, expected combinational stall, stall_count visible during the
// cycle, and the rs/rt selects expected after the edge (queued, compared on
// the following cycle). Counter width is reduced to 4 bits for saturation.
// -----------------------------------------------------------------------------
module tb_forward_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset_n, hold, flush, id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
   logic       stall;
   logic [1:0] rsMux, rtMux;
   logic [3:0] stall_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   forward_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .hold         (hold),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_is_load   (id_is_load),
      .stall        (stall),
      .rsMux        (rsMux),
      .rtMux        (rtMux),
      .stall_count  (stall_count)
   );

   typedef struct {
      logic       rst_n, hold, flush, valid;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] dest;
      logic       wr, ld;
      logic       e_stall;
      logic [1:0] e_rs, e_rt;
      logic [3:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [1:0] rs, rt;
   } sel_t;

   vec_t vecs[$];
   sel_t sb[$];
   int   step_no = 0;

   function automatic vec_t mk(input logic r, h, f, v,
                               input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt,
                               input logic [4:0] d, input logic wr, ld, es,
                               input logic [1:0] ers, ert, input logic [3:0] ec);
      vec_t x;
      x.rst_n = r;  x.hold = h;  x.flush = f;  x.valid = v;
      x.rs = rs;    x.urs = urs; x.rt = rt;    x.urt = urt;
      x.dest = d;   x.wr = wr;   x.ld = ld;
      x.e_stall = es; x.e_rs = ers; x.e_rt = ert; x.e_cnt = ec;
      return x;
   endfunction

   function automatic vec_t nop(input logic h, input logic [1:0] ers, ert,
                                input logic [3:0] ec);
      return mk(1, h, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ers, ert, ec);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset_n      = v.rst_n;
      hold         = v.hold;
      flush        = v.flush;
      id_valid     = v.valid;
      id_rs        = v.rs;
      id_uses_rs   = v.urs;
      id_rt        = v.rt;
      id_uses_rt   = v.urt;
      id_dest      = v.dest;
      id_reg_write = v.wr;
      id_is_load   = v.ld;
   endtask

   task automatic step(input vec_t v);
      sel_t e;
      @(negedge clock);
      drive(v);
      #1;
      step_no++;
      check($sformatf("stall@%0d", step_no), 16'(stall), 16'(v.e_stall));
      check($sformatf("count@%0d", step_no), 16'(stall_count), 16'(v.e_cnt));
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard@%0d: got empty queue, expected entry", step_no);
      end else begin
         e = sb.pop_front();
         check($sformatf("rsMux@%0d", step_no), 16'(rsMux), 16'(e.rs));
         check($sformatf("rtMux@%0d", step_no), 16'(rtMux), 16'(e.rt));
      end
      e.rs = v.e_rs;
      e.rt = v.e_rt;
      sb.push_back(e);
   endtask

   function automatic vec_t rand_reset();
      vec_t x;
      x = mk(0, 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
      return x;
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      sel_t s0;
      int   c;

      // ALU chain
      vecs.push_back(mk(1,0,0,1,  1,1,  2,1,  3,1,0, 0, 0,0, 0)); // add $3,$1,$2
      vecs.push_back(mk(1,0,0,1,  3,1,  4,1,  5,1,0, 0, 1,0, 0)); // sub $5,$3,$4
      vecs.push_back(mk(1,0,0,1,  5,0,  3,1, 11,1,0, 0, 0,2, 0)); // rs unused, rt=$3 in MEM
      vecs.push_back(nop(0, 0,0, 0));
      vecs.push_back(mk(1,0,0,1,  1,1,  2,1,  7,1,0, 0, 0,0, 0)); // add $7
      vecs.push_back(mk(1,0,0,1, 11,1, 12,1, 10,1,0, 0, 0,0, 0)); // independent
      vecs.push_back(mk(1,0,0,1,  7,1,  4,1, 13,1,0, 0, 2,0, 0)); // reads $7 -> 10
      vecs.push_back(nop(0, 0,0, 0));
      // Load-use
      vecs.push_back(mk(1,0,0,1,  1,1,  8,0,  8,1,1, 0, 0,0, 0)); // lw $8
      vecs.push_back(mk(1,0,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 0)); // add $9 stalls
      vecs.push_back(mk(1,0,0,1,  8,1,  8,1,  9,1,0, 0, 2,2, 1)); // add $9 issues
      vecs.push_back(nop(0, 0,0, 1));
      // Priority and $0
      vecs.push_back(mk(1,0,0,1,  1,1,  1,1,  2,1,0, 0, 0,0, 1)); // add $2
      vecs.push_back(mk(1,0,0,1,  3,1,  3,1,  2,1,0, 0, 0,0, 1)); // add $2
      vecs.push_back(mk(1,0,0,1,  2,1,  0,1,  6,1,0, 0, 1,0, 1)); // or $6,$2,$0
      vecs.push_back(mk(1,0,0,1,  1,1,  0,0,  0,1,1, 0, 0,0, 1)); // lw $0
      vecs.push_back(mk(1,0,0,1,  0,1,  0,1,  4,1,0, 0, 0,0, 1)); // reads $0
      vecs.push_back(nop(0, 0,0, 1));
      // Flush beats stall
      vecs.push_back(mk(1,0,0,1,  1,1,  0,0,  8,1,1, 0, 0,0, 1)); // lw $8
      vecs.push_back(mk(1,0,1,1,  8,1,  8,1,  9,1,0, 0, 0,0, 1)); // flushed reader
      vecs.push_back(nop(0, 0,0, 1));
      // Hold mid-stall, then hold with live selects
      vecs.push_back(mk(1,0,0,1,  1,1,  0,0,  8,1,1, 0, 0,0, 1)); // lw $8
      vecs.push_back(mk(1,1,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 1));
      vecs.push_back(mk(1,1,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 1));
      vecs.push_back(mk(1,1,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 1));
      vecs.push_back(mk(1,0,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 1)); // counts here
      vecs.push_back(mk(1,0,0,1,  8,1,  8,1,  9,1,0, 0, 2,2, 2));
      vecs.push_back(nop(1, 2,2, 2));                              // selects frozen
      vecs.push_back(nop(0, 0,0, 2));
      // Reset mid-stall
      vecs.push_back(mk(1,0,0,1,  1,1,  0,0,  8,1,1, 0, 0,0, 2)); // lw $8
      vecs.push_back(mk(0,0,0,1,  8,1,  8,1,  9,1,0, 1, 0,0, 2)); // reset edge
      vecs.push_back(mk(1,0,0,1,  8,1,  8,1,  9,1,0, 0, 0,0, 0)); // stall gone
      vecs.push_back(nop(0, 0,0, 0));

      // First reset cycle: DUT state unknown before it, so nothing is checked.
      @(negedge clock);
      drive(rand_reset());
      s0.rs = 2'b00;
      s0.rt = 2'b00;
      sb.push_back(s0);

      // Second reset cycle with random inputs, then the vector table.
      step(rand_reset());
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i]);
      end

      // Saturation: 16 load-use stalls into a 4-bit counter.
      c = 0;
      for (int i = 0; i < 16; i++) begin
         step(mk(1,0,0,1, 1,1, 0,0, 8,1,1, 0, 0,0, 4'(c)));
         step(mk(1,0,0,1, 8,1, 8,1, 9,1,0, 1, 0,0, 4'(c)));
         if (c < 15) c++;
         step(mk(1,0,0,1, 8,1, 8,1, 9,1,0, 0, 2,2, 4'(c)));
      end
      step(nop(0, 0,0, 4'd15));
      step(nop(0, 0,0, 4'd15));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
